pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer; successor to the fixed 32-bit PC register.
//  Holds the fetch PC and selects next PC from the prioritised sources below.
//  Sources: exception vector, branch, jump/call, return, sequential.
//  Contains a small return-address stack (RAS) for call/return.
//  Sits between the hazard unit (PCWrite stall) and instruction memory.
// PARAMETERS
//  WIDTH         32        PC / address width in bits
//  RESET_VECTOR  0         PC value loaded on reset
//  EXC_VECTOR    32'h80    PC loaded on Exception (truncated to WIDTH)
//  INC           4         sequential increment; power of two, >=1
//  RAS_DEPTH     4         return-address-stack entries; power of two, >=2
// PORTS
//  Clk           in   1           clock, rising edge
//  Reset         in   1           asynchronous, active-low reset
//  PCWrite       in   1           1 = PC may advance; 0 = stall (hold PC, RAS)
//  Exception     in   1           redirect to EXC_VECTOR; ignores PCWrite
//  BranchTaken   in   1           redirect to BranchTarget
//  BranchTarget  in   WIDTH       branch destination
//  Jump          in   1           redirect to JumpTarget
//  Call          in   1           with Jump: also push PCResult+INC onto RAS
//  JumpTarget    in   WIDTH       jump/call destination
//  Return        in   1           redirect to RAS top (pop); JrTarget if RAS empty
//  JrTarget      in   WIDTH       register-file return address (fallback)
//  PCResult      out  WIDTH       current fetch PC (registered)
//  PCPlusInc     out  WIDTH       PCResult+INC, modulo 2^WIDTH (combinational)
//  EPC           out  WIDTH       PCResult captured on Exception (registered)
//  RasEmpty      out  1           RAS count == 0
//  RasFull       out  1           RAS count == RAS_DEPTH
//  RasUnderflow  out  1           1-cycle pulse: Return accepted with RAS empty
//  Misaligned    out  1           |(PCResult & (INC-1)); combinational
// BEHAVIOUR
//  Reset low (async): PCResult=RESET_VECTOR, EPC=0, RAS count=0, ptr=0,
//   RasUnderflow=0; entries need not be cleared. Held while Reset low.
//  Updates occur on rising Clk only; 1-cycle latency from inputs to PCResult.
//  Priority, first match wins:
//   1 Exception: PC<=EXC_VECTOR, EPC<=PCResult, RAS count<=0. Ignores PCWrite.
//   2 PCWrite=0: PC, RAS, EPC hold; RasUnderflow<=0. All other inputs ignored.
//   3 BranchTaken: PC<=BranchTarget; RAS untouched.
//   4 Jump: PC<=JumpTarget; if Call also push PCResult+INC.
//   5 Return: PC<=RAS top if count>0 (pop), else JrTarget and RasUnderflow<=1.
//   6 else: PC<=PCResult+INC, wraps modulo 2^WIDTH.
//  Call without Jump is ignored. Jump+Return: Jump wins, no pop.
//  Jump+Call+Return together: PC<=JumpTarget; pop then push, count unchanged;
//   top becomes PCResult+INC.
//  RAS is circular: push writes at ptr, ptr<=ptr+1 mod RAS_DEPTH.
//   count saturates at RAS_DEPTH; push when full overwrites oldest entry.
//  Pop: ptr<=ptr-1 mod RAS_DEPTH, count<=count-1.
//  RasUnderflow is high only in the cycle after an underflowing Return.
//  EPC changes only on Exception.
//  Misaligned is flag only; sequencer never corrects PC alignment.
// TESTING
//  Reset low mid-run (PC=0x40) -> PCResult=0 immediately, before next edge;
//   release, PCWrite=1 -> 4, 8, 12.
//  PCWrite=0 three cycles at PC=0x10 with BranchTaken=1 -> PC stays 0x10;
//   PCWrite=1 -> 0x14 if branch dropped, else BranchTarget.
//  Exception with PCWrite=0 at PC=0x24 -> PC=0x80, EPC=0x24, RasEmpty=1.
//  Call from 0x100 to 0x200, then Return -> PC=0x104, RasEmpty=1.
//  5 nested Calls (DEPTH=4), then 5 Returns -> first 4 pop newest-first;
//   5th uses JrTarget and pulses RasUnderflow for one cycle.
//  WIDTH=8 at PC=0xFC -> sequential next PC=0x00.
//  BranchTarget=0x102 -> Misaligned=1 the following cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer. Holds the fetch PC and selects the next PC from
//   prioritised sources: exception vector, branch, jump/call, return,
//   sequential. A small circular return-address stack (RAS) serves
//   call/return pairs; a register-file address is the fallback when the RAS
//   has nothing to give.
//
// Parameters
//   WIDTH         PC / address width in bits
//   RESET_VECTOR  PC value loaded on reset
//   EXC_VECTOR    PC loaded on Exception (truncated to WIDTH)
//   INC           sequential increment; power of two, >= 1
//   RAS_DEPTH     return-address-stack entries; power of two, >= 2
//
// Ports
//   Clk           in   clock, rising edge
//   Reset         in   asynchronous, active-low reset
//   PCWrite       in   1 = PC may advance; 0 = stall (hold PC, RAS, EPC)
//   Exception     in   redirect to EXC_VECTOR; ignores PCWrite
//   BranchTaken   in   redirect to BranchTarget
//   BranchTarget  in   branch destination
//   Jump          in   redirect to JumpTarget
//   Call          in   with Jump: also push PCResult+INC onto the RAS
//   JumpTarget    in   jump/call destination
//   Return        in   redirect to RAS top (pop); JrTarget if RAS empty
//   JrTarget      in   register-file return address (fallback)
//   PCResult      out  current fetch PC (registered)
//   PCPlusInc     out  PCResult+INC modulo 2^WIDTH (combinational)
//   EPC           out  PCResult captured on Exception (registered)
//   RasEmpty      out  RAS count == 0
//   RasFull       out  RAS count == RAS_DEPTH
//   RasUnderflow  out  1-cycle pulse: Return accepted with RAS empty
//   Misaligned    out  PCResult not a multiple of INC (combinational)
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned EXC_VECTOR   = 32'h80,
  parameter int unsigned INC          = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic             Exception,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic             Call,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Return,
  input  logic [WIDTH-1:0] JrTarget,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlusInc,
  output logic [WIDTH-1:0] EPC,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasUnderflow,
  output logic             Misaligned
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_M  = WIDTH'(INC - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(RAS_DEPTH);

  // Winning next-PC source after priority resolution.
  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_HOLD,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_RET,
    SRC_SEQ
  } pc_src_e;

  pc_src_e src;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic             push_en;
  logic [PW-1:0]    push_idx;

  logic [WIDTH-1:0] pc_plus;
  logic [PW-1:0]    ptr_m1;
  logic             ras_empty;
  logic             ras_full;

  // Sequential successor and RAS top; both wrap naturally because WIDTH and
  // RAS_DEPTH define power-of-two moduli.
  assign pc_plus   = pc_q + INC_W;
  assign ptr_m1    = ptr_q - PW'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);

  // Priority decode, first match wins.
  always_comb begin
    if (Exception)      src = SRC_EXC;
    else if (!PCWrite)  src = SRC_HOLD;
    else if (BranchTaken) src = SRC_BRANCH;
    else if (Jump)      src = SRC_JUMP;
    else if (Return)    src = SRC_RET;
    else                src = SRC_SEQ;
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    pc_d     = pc_q;
    epc_d    = epc_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    unf_d    = 1'b0;
    push_en  = 1'b0;
    push_idx = ptr_q;

    unique case (src)
      SRC_EXC: begin
        pc_d  = EXC_PC;
        epc_d = pc_q;
        cnt_d = '0;
      end
      SRC_HOLD: begin
        // Stall: everything holds, the underflow pulse drops.
      end
      SRC_BRANCH: begin
        pc_d = BranchTarget;
      end
      SRC_JUMP: begin
        pc_d = JumpTarget;
        if (Call) begin
          push_en = 1'b1;
          if (Return && !ras_empty) begin
            // Pop-then-push collapses to replacing the current top in place.
            push_idx = ptr_m1;
          end else begin
            // Full stack: ptr advances onto the oldest entry and count holds,
            // so the oldest return address is silently lost.
            ptr_d = ptr_q + PW'(1);
            if (!ras_full) cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SRC_RET: begin
        if (!ras_empty) begin
          pc_d  = ras_q[ptr_m1];
          ptr_d = ptr_m1;
          cnt_d = cnt_q - CW'(1);
        end else begin
          pc_d  = JrTarget;
          unf_d = 1'b1;
        end
      end
      default: begin
        pc_d = pc_plus;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q  <= RST_PC;
      epc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      unf_q <= unf_d;
    end
  end

  // NOTE: RAS entries carry no reset; count gates every read, so stale data is
  // never observed and the array can map onto reset-less storage.
  always_ff @(posedge Clk) begin
    if (push_en) ras_q[push_idx] <= pc_plus;
  end

  assign PCResult     = pc_q;
  assign PCPlusInc    = pc_plus;
  assign EPC          = epc_q;
  assign RasEmpty     = ras_empty;
  assign RasFull      = ras_full;
  assign RasUnderflow = unf_q;
  assign Misaligned   = |(pc_q & ALIGN_M);

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer. A default 32-bit instance covers reset,
//   stall, exception, branch, call/return and RAS overflow/underflow; an 8-bit
//   instance covers sequential wrap-around. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset;
  logic        PCWrite, Exception, BranchTaken, Jump, Call, Return;
  logic [31:0] BranchTarget, JumpTarget, JrTarget;
  logic [31:0] PCResult, PCPlusInc, EPC;
  logic        RasEmpty, RasFull, RasUnderflow, Misaligned;

  logic        pcw8, br8;
  logic [7:0]  brt8;
  logic [7:0]  pc8, pcinc8, epc8;
  logic        empty8, full8, unf8, mis8;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCWrite      (PCWrite),
    .Exception    (Exception),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .Call         (Call),
    .JumpTarget   (JumpTarget),
    .Return       (Return),
    .JrTarget     (JrTarget),
    .PCResult     (PCResult),
    .PCPlusInc    (PCPlusInc),
    .EPC          (EPC),
    .RasEmpty     (RasEmpty),
    .RasFull      (RasFull),
    .RasUnderflow (RasUnderflow),
    .Misaligned   (Misaligned)
  );

  pc_sequencer #(.WIDTH(8)) dut8 (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCWrite      (pcw8),
    .Exception    (1'b0),
    .BranchTaken  (br8),
    .BranchTarget (brt8),
    .Jump         (1'b0),
    .Call         (1'b0),
    .JumpTarget   (8'h00),
    .Return       (1'b0),
    .JrTarget     (8'h00),
    .PCResult     (pc8),
    .PCPlusInc    (pcinc8),
    .EPC          (epc8),
    .RasEmpty     (empty8),
    .RasFull      (full8),
    .RasUnderflow (unf8),
    .Misaligned   (mis8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit away from the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctl();
    Exception   = 1'b0;
    BranchTaken = 1'b0;
    Jump        = 1'b0;
    Call        = 1'b0;
    Return      = 1'b0;
    PCWrite     = 1'b1;
  endtask

  initial begin
    Reset        = 1'b1;
    clear_ctl();
    BranchTarget = '0;
    JumpTarget   = '0;
    JrTarget     = '0;
    pcw8         = 1'b0;
    br8          = 1'b0;
    brt8         = '0;

    // Reset state
    #1 Reset = 1'b0;
    #2;
    check("rst_pc", PCResult, 32'h0);
    check("rst_epc", EPC, 32'h0);
    check("rst_empty", {31'b0, RasEmpty}, 32'h1);
    check("rst_full", {31'b0, RasFull}, 32'h0);
    check("rst_unf", {31'b0, RasUnderflow}, 32'h0);
    check("rst_pcinc", PCPlusInc, 32'h4);
    step();
    check("rst_hold", PCResult, 32'h0);
    Reset = 1'b1;

    // Sequential run up to 0x40, then asynchronous reset mid-run
    for (int i = 1; i <= 16; i++) step();
    check("seq_0x40", PCResult, 32'h40);
    Reset = 1'b0;
    #1;
    check("async_rst_pc", PCResult, 32'h0);
    step();
    check("rst_held_pc", PCResult, 32'h0);
    Reset = 1'b1;
    step(); check("post_rst_4", PCResult, 32'h4);
    step(); check("post_rst_8", PCResult, 32'h8);
    step(); check("post_rst_12", PCResult, 32'hC);
    step(); check("seq_0x10", PCResult, 32'h10);

    // Stall with branch pending
    PCWrite = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", PCResult, 32'h10);
    end
    PCWrite = 1'b1; BranchTaken = 1'b0;
    step(); check("stall_release_seq", PCResult, 32'h14);
    PCWrite = 1'b0; BranchTaken = 1'b1;
    step(); check("stall_hold2", PCResult, 32'h14);
    PCWrite = 1'b1;
    step(); check("stall_release_br", PCResult, 32'h300);

    // Call to set up a non-empty RAS, then exception while stalled at 0x24
    BranchTarget = 32'h50;
    step(); check("br_0x50", PCResult, 32'h50);
    BranchTaken = 1'b0; Jump = 1'b1; Call = 1'b1; JumpTarget = 32'h20;
    step();
    check("call_pc", PCResult, 32'h20);
    check("call_nonempty", {31'b0, RasEmpty}, 32'h0);
    clear_ctl();
    step(); check("seq_0x24", PCResult, 32'h24);
    Exception = 1'b1; PCWrite = 1'b0;
    step();
    check("exc_pc", PCResult, 32'h80);
    check("exc_epc", EPC, 32'h24);
    check("exc_empty", {31'b0, RasEmpty}, 32'h1);
    clear_ctl();
    step();
    check("post_exc_pc", PCResult, 32'h84);
    check("epc_stable", EPC, 32'h24);

    // Call 0x100 -> 0x200, then Return
    BranchTaken = 1'b1; BranchTarget = 32'h100;
    step(); check("br_0x100", PCResult, 32'h100);
    clear_ctl(); Jump = 1'b1; Call = 1'b1; JumpTarget = 32'h200;
    step(); check("call_0x200", PCResult, 32'h200);
    clear_ctl(); Return = 1'b1;
    step();
    check("ret_0x104", PCResult, 32'h104);
    check("ret_empty", {31'b0, RasEmpty}, 32'h1);
    check("ret_no_unf", {31'b0, RasUnderflow}, 32'h0);

    // Call without Jump is ignored
    clear_ctl(); Call = 1'b1;
    step();
    check("call_only_seq", PCResult, 32'h108);
    check("call_only_empty", {31'b0, RasEmpty}, 32'h1);

    // Five nested calls into a 4-deep RAS, then five returns
    clear_ctl(); BranchTaken = 1'b1; BranchTarget = 32'h1000;
    step();
    clear_ctl(); Jump = 1'b1; Call = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      JumpTarget = 32'(k) << 12;
      step();
      check("nest_call_pc", PCResult, 32'(k) << 12);
      if (k == 4) check("nest_not_full", {31'b0, RasFull}, 32'h0);
      if (k >= 5) check("nest_full", {31'b0, RasFull}, 32'h1);
    end
    clear_ctl(); Return = 1'b1; JrTarget = 32'h7770;
    for (int k = 5; k >= 2; k--) begin
      step();
      check("nest_ret_pc", PCResult, (32'(k) << 12) + 32'h4);
      check("nest_ret_unf", {31'b0, RasUnderflow}, 32'h0);
    end
    check("nest_drained", {31'b0, RasEmpty}, 32'h1);
    step();
    check("underflow_pc", PCResult, 32'h7770);
    check("underflow_pulse", {31'b0, RasUnderflow}, 32'h1);
    clear_ctl();
    step();
    check("underflow_drop", {31'b0, RasUnderflow}, 32'h0);
    check("after_unf_pc", PCResult, 32'h7774);
    check("aligned", {31'b0, Misaligned}, 32'h0);

    // Jump+Call+Return: top replaced, count unchanged
    BranchTaken = 1'b1; BranchTarget = 32'h400;
    step();
    clear_ctl(); Jump = 1'b1; Call = 1'b1; JumpTarget = 32'h500;
    step();
    Return = 1'b1; JumpTarget = 32'h600;
    step(); check("jcr_pc", PCResult, 32'h600);
    clear_ctl(); Return = 1'b1;
    step();
    check("jcr_ret_pc", PCResult, 32'h504);
    check("jcr_ret_empty", {31'b0, RasEmpty}, 32'h1);

    // Jump+Return without Call: jump wins, no pop
    clear_ctl(); Jump = 1'b1; Call = 1'b1; JumpTarget = 32'h700;
    step();
    Call = 1'b0; Return = 1'b1; JumpTarget = 32'h800;
    step();
    check("jr_pc", PCResult, 32'h800);
    check("jr_no_pop", {31'b0, RasEmpty}, 32'h0);
    clear_ctl(); Return = 1'b1;
    step(); check("jr_ret_pc", PCResult, 32'h508);

    // Misaligned branch target
    clear_ctl(); BranchTaken = 1'b1; BranchTarget = 32'h102;
    step();
    check("mis_pc", PCResult, 32'h102);
    check("mis_flag", {31'b0, Misaligned}, 32'h1);
    check("mis_pcinc", PCPlusInc, 32'h106);
    clear_ctl();
    step();
    check("mis_seq_pc", PCResult, 32'h106);
    check("mis_flag2", {31'b0, Misaligned}, 32'h1);

    // WIDTH=8 wrap
    check("w8_stalled_pc", {24'b0, pc8}, 32'h0);
    pcw8 = 1'b1; br8 = 1'b1; brt8 = 8'hFC;
    step();
    check("w8_pc_fc", {24'b0, pc8}, 32'hFC);
    check("w8_pcinc_wrap", {24'b0, pcinc8}, 32'h00);
    br8 = 1'b0;
    step();
    check("w8_wrap_pc", {24'b0, pc8}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
